// File: rtl/final_cpu_pkg.sv
// rtl/final_cpu_pkg.sv - shared state encodings, opcodes and jump conditions for final_cpu
package final_cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_FETCH2 = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;
  localparam logic [3:0] OP_JMP = 4'hD;
  localparam logic [3:0] OP_LDB = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] JC_ALWAYS = 2'b00;
  localparam logic [1:0] JC_Z      = 2'b01;
  localparam logic [1:0] JC_C      = 2'b10;
  localparam logic [1:0] JC_NZ     = 2'b11;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

  // CMP only touches flags; MOV..SHR and LDB write Rd
  function automatic logic writes_reg(input logic [3:0] op);
    return ((op >= OP_MOV) && (op <= OP_SHR)) || (op == OP_LDB);
  endfunction

endpackage

// File: rtl/final_cpu_alu.sv
// rtl/final_cpu_alu.sv - combinational 8-bit ALU with carry/zero flag generation
module final_cpu_alu
  import final_cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [7:0] in1_i,
  input  logic [7:0] in2_i,
  input  logic       c_i,
  output logic [7:0] result_o,
  output logic       c_next_o,
  output logic       z_next_o,
  output logic       c_we_o,
  output logic       z_we_o
);

  logic [8:0] sum;
  logic [8:0] diff;
  logic       c_new;

  always_comb begin
    sum      = {1'b0, in1_i} + {1'b0, in2_i};
    // bit 8 of the widened difference is the borrow
    diff     = {1'b0, in1_i} - {1'b0, in2_i};
    result_o = in1_i;
    c_new    = 1'b0;
    case (opcode_i)
      OP_ADD:         {c_new, result_o} = sum;
      OP_SUB, OP_CMP: {c_new, result_o} = diff;
      OP_AND:         result_o = in1_i & in2_i;
      OP_OR:          result_o = in1_i | in2_i;
      OP_XOR:         result_o = in1_i ^ in2_i;
      OP_NOT:         result_o = ~in1_i;
      OP_INC:         result_o = in1_i + 8'd1;
      OP_DEC:         result_o = in1_i - 8'd1;
      OP_SHL: begin
        result_o = {in1_i[6:0], 1'b0};
        c_new    = in1_i[7];
      end
      OP_SHR: begin
        result_o = {1'b0, in1_i[7:1]};
        c_new    = in1_i[0];
      end
      default:        result_o = in1_i;
    endcase
    c_we_o   = is_alu_op(opcode_i);
    z_we_o   = is_alu_op(opcode_i);
    c_next_o = c_we_o ? c_new : c_i;
    z_next_o = (result_o == 8'h00);
  end

endmodule

// File: rtl/final_cpu.sv
// rtl/final_cpu.sv - multi-cycle 8-bit core: 256x8 memory, four registers, fetch/decode/exec/wb controller
module final_cpu
  import final_cpu_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        done,
  output logic        c,
  output logic        z,
  output logic        clk2,
  output logic        clk3,
  output logic [7:0]  out1,
  output logic [7:0]  out2,
  output logic [7:0]  out3,
  output logic [7:0]  out4,
  output logic [7:0]  a_out,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic [3:0]  opcode,
  output logic [3:0]  imm4,
  output logic [1:0]  Rd,
  output logic [1:0]  Rs,
  output logic [1:0]  imm2,
  output logic        r1,
  output logic        w1,
  output logic        r2,
  output logic        w2,
  output logic        act1,
  output logic        act2,
  output logic        a_act,
  output logic [7:0]  num,
  output logic [2:0]  state,
  output logic        d_r,
  output logic        d_d
);

  state_e     state_q, state_d;
  logic [7:0] mem_q [256];
  logic [7:0] regs_q [4];
  logic [7:0] pc_q, ir_q, op_q, res_q;
  logic       c_q, z_q, dd_q;
  logic [1:0] div_q;
  logic [7:0] alu_res;
  logic       alu_c, alu_z, alu_cwe, alu_zwe, jmp_taken;

  assign opcode = ir_q[7:4];
  assign imm4   = ir_q[3:0];
  assign Rd     = ir_q[3:2];
  assign Rs     = ir_q[1:0];
  assign imm2   = ir_q[1:0];
  assign in1    = regs_q[Rd];
  assign in2    = regs_q[Rs];
  assign out1   = regs_q[0];
  assign out2   = regs_q[1];
  assign out3   = regs_q[2];
  assign out4   = regs_q[3];
  assign a_out  = alu_res;
  assign num    = pc_q;
  assign state  = state_q;
  assign c      = c_q;
  assign z      = z_q;
  assign clk2   = div_q[0];
  assign clk3   = div_q[1];
  assign d_d    = dd_q;
  assign w1     = done;

  assign jmp_taken = (imm2 == JC_ALWAYS) | ((imm2 == JC_Z) & z_q) |
                     ((imm2 == JC_C) & c_q) | ((imm2 == JC_NZ) & ~z_q);

  final_cpu_alu u_alu (
    .opcode_i (opcode),
    .in1_i    (in1),
    .in2_i    (in2),
    .c_i      (c_q),
    .result_o (alu_res),
    .c_next_o (alu_c),
    .z_next_o (alu_z),
    .c_we_o   (alu_cwe),
    .z_we_o   (alu_zwe)
  );

  // Load port is independent of reset and of the controller; memory is never cleared
  always_ff @(posedge clk1) begin
    if (done) mem_q[in[15:8]] <= in[7:0];
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      div_q <= 2'd0;
      dd_q  <= 1'b0;
    end else begin
      div_q <= div_q + 2'd1;
      dd_q  <= done;
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = ((opcode == OP_JMP) || (opcode == OP_LDB)) ? S_FETCH2 : S_EXEC;
      S_FETCH2: state_d = S_EXEC;
      S_EXEC:   state_d = (opcode == OP_HLT) ? S_HALT : S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    r1    = 1'b0;
    r2    = 1'b0;
    w2    = 1'b0;
    act1  = 1'b0;
    act2  = 1'b0;
    a_act = 1'b0;
    d_r   = 1'b0;
    case (state_q)
      S_FETCH:  begin r1 = 1'b1; act1 = 1'b1; end
      S_DECODE: begin r2 = 1'b1; d_r = 1'b1; end
      S_FETCH2: begin r1 = 1'b1; act1 = 1'b1; d_r = 1'b1; end
      S_EXEC:   begin act2 = 1'b1; a_act = is_alu_op(opcode); d_r = 1'b1; end
      S_WB:     begin w2 = writes_reg(opcode); d_r = 1'b1; end
      default:  ;
    endcase
  end

  // Result is staged in res_q during EXEC so an abort before WB leaves registers untouched
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q  <= 8'h00;
      ir_q  <= 8'h00;
      op_q  <= 8'h00;
      res_q <= 8'h00;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q <= mem_q[pc_q];
          pc_q <= pc_q + 8'd1;
        end
        S_FETCH2: begin
          op_q <= mem_q[pc_q];
          pc_q <= pc_q + 8'd1;
        end
        S_EXEC: begin
          res_q <= (opcode == OP_MOV) ? in2 : (opcode == OP_LDB) ? op_q : alu_res;
          if (alu_cwe) c_q <= alu_c;
          if (alu_zwe) z_q <= alu_z;
          if ((opcode == OP_JMP) && jmp_taken) pc_q <= op_q;
        end
        S_WB: begin
          if (w2) regs_q[Rd] <= res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_final_cpu.sv
// tb/tb_final_cpu.sv - directed programs checked against an instruction-level model of final_cpu
module tb_final_cpu;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic        done = 1'b0;
  logic [15:0] in   = 16'h0000;
  logic        c, z, clk2, clk3, r1, w1, r2, w2, act1, act2, a_act, d_r, d_d;
  logic [7:0]  out1, out2, out3, out4, a_out, in1, in2, num;
  logic [3:0]  opcode, imm4;
  logic [1:0]  Rd, Rs, imm2;
  logic [2:0]  state;

  final_cpu dut (
    .clk1(clk1), .rst(rst), .in(in), .done(done), .c(c), .z(z), .clk2(clk2), .clk3(clk3),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4), .a_out(a_out), .in1(in1), .in2(in2),
    .opcode(opcode), .imm4(imm4), .Rd(Rd), .Rs(Rs), .imm2(imm2), .r1(r1), .w1(w1), .r2(r2),
    .w2(w2), .act1(act1), .act2(act2), .a_act(a_act), .num(num), .state(state), .d_r(d_r),
    .d_d(d_d)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Instruction-level model: architectural state only, one whole instruction per step
  logic [7:0] m_mem [256];
  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic       m_c, m_z, m_halt;
  int         m_len;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; m_len = 0;
  endtask

  task automatic m_step();
    logic [7:0] ir, opb, a, b, res;
    logic [8:0] t;
    int d;
    ir = m_mem[m_pc]; m_pc = m_pc + 8'd1; m_len = 4; opb = 8'h00;
    if (ir[7:4] == 4'hD || ir[7:4] == 4'hE) begin
      opb = m_mem[m_pc]; m_pc = m_pc + 8'd1; m_len = 5;
    end
    d = int'(ir[3:2]);
    a = m_r[d]; b = m_r[ir[1:0]];
    case (ir[7:4])
      4'h1: m_r[d] = b;
      4'h2: begin t = {1'b0, a} + {1'b0, b}; m_r[d] = t[7:0]; m_c = t[8]; m_z = (t[7:0] == 0); end
      4'h3: begin m_r[d] = a - b; m_c = (a < b); m_z = (a == b); end
      4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
        case (ir[7:4])
          4'h4: res = a & b;
          4'h5: res = a | b;
          4'h6: res = a ^ b;
          4'h7: res = ~a;
          4'h8: res = a + 8'd1;
          default: res = a - 8'd1;
        endcase
        m_r[d] = res; m_c = 1'b0; m_z = (res == 0);
      end
      4'hA: begin res = a * 2; m_c = a[7]; m_r[d] = res; m_z = (res == 0); end
      4'hB: begin res = a / 2; m_c = a[0]; m_r[d] = res; m_z = (res == 0); end
      4'hC: begin m_c = (a < b); m_z = (a == b); end
      4'hD: if (ir[1:0] == 2'd0 || (ir[1:0] == 2'd1 && m_z) || (ir[1:0] == 2'd2 && m_c) ||
                (ir[1:0] == 2'd3 && !m_z)) m_pc = opb;
      4'hE: m_r[d] = opb;
      4'hF: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic cmp_arch(input string tag);
    check({tag, " R0"}, out1, m_r[0]);
    check({tag, " R1"}, out2, m_r[1]);
    check({tag, " R2"}, out3, m_r[2]);
    check({tag, " R3"}, out4, m_r[3]);
    check({tag, " pc"}, num, m_pc);
    check({tag, " c"}, c, m_c);
    check({tag, " z"}, z, m_z);
  endtask

  logic chk_en    = 1'b0;
  logic first     = 1'b1;
  logic halt_seen = 1'b0;
  int   cyc       = 0;

  always @(negedge clk1) begin
    if (chk_en) begin
      if (state == 3'd1) begin
        if (!first) check("instr latency", cyc, m_len);
        cmp_arch("boundary");
        check("ran past HLT", m_halt, 1'b0);
        first = 1'b0;
        cyc   = 0;
        m_step();
      end else if (state == 3'd7 && !halt_seen) begin
        halt_seen = 1'b1;
        check("halt expected", m_halt, 1'b1);
        cmp_arch("halt");
      end
      cyc++;
    end
  end

  logic [7:0] pq [$];

  task automatic put(input logic [7:0] a, input logic [7:0] d);
    done = 1'b1; in = {a, d}; m_mem[a] = d;
    @(posedge clk1); #2;
    done = 1'b0;
  endtask

  task automatic load(input logic [7:0] base);
    foreach (pq[i]) put(base + 8'(i), pq[i]);
  endtask

  task automatic go();
    rst = 1'b0; m_reset(); first = 1'b1; halt_seen = 1'b0; cyc = 0; chk_en = 1'b1;
  endtask

  task automatic start();
    rst = 1'b1;
    @(posedge clk1); #2;
    go();
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (state !== 3'd7 && n < 400) begin @(negedge clk1); n++; end
    check({name, " halted"}, state, 3'd7);
    @(negedge clk1);
    @(posedge clk1); #2;
    chk_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_reset();
    @(posedge clk1); @(posedge clk1); #1;
    check("rst state", state, 3'd1);
    check("rst pc", num, 8'h00);
    check("rst R0", out1, 8'h00);
    check("rst R3", out4, 8'h00);
    check("rst c", c, 1'b0);
    check("rst z", z, 1'b0);
    check("rst clk2", clk2, 1'b0);
    check("rst clk3", clk3, 1'b0);
    check("rst d_d", d_d, 1'b0);
    check("rst r1", r1, 1'b1);
    check("rst d_r", d_r, 1'b0);
    #1;

    // LDB R0,5 ; LDB R1,3 ; ADD R0,R1 ; HLT
    pq = '{8'hE0, 8'h05, 8'hE4, 8'h03, 8'h21, 8'hF0};
    load(8'h00);
    start();
    repeat (23) @(posedge clk1);
    #1;
    check("t1 out1", out1, 8'h08);
    check("t1 out2", out2, 8'h03);
    check("t1 state", state, 3'd7);
    check("t1 c", c, 1'b0);
    check("t1 z", z, 1'b0);
    check("t1 clk2", clk2, 1'b1);
    check("t1 clk3", clk3, 1'b1);
    wait_halt("t1");
    repeat (4) @(posedge clk1);
    #1;
    check("halt holds state", state, 3'd7);
    check("halt holds pc", num, 8'h06);

    // FF + 01 wraps to 00 with carry and zero
    pq = '{8'hE0, 8'hFF, 8'hE4, 8'h01, 8'h21, 8'hF0};
    load(8'h00);
    start();
    wait_halt("t2");
    check("t2 out1", out1, 8'h00);
    check("t2 c", c, 1'b1);
    check("t2 z", z, 1'b1);

    // 00 - 01 borrows
    pq = '{8'hE0, 8'h00, 8'hE4, 8'h01, 8'h31, 8'hF0};
    load(8'h00);
    start();
    wait_halt("t3a");
    check("t3a out1", out1, 8'hFF);
    check("t3a c", c, 1'b1);
    check("t3a z", z, 1'b0);
    pq = '{8'hE0, 8'h00, 8'hE4, 8'h01, 8'h31, 8'hC0, 8'hF0};
    load(8'h00);
    start();
    wait_halt("t3b");
    check("t3b out1", out1, 8'hFF);
    check("t3b z", z, 1'b1);

    // countdown loop with JMP !Z
    pq = '{8'hE0, 8'h03, 8'h90, 8'hD3, 8'h02, 8'hF0};
    load(8'h00);
    start();
    wait_halt("t4");
    check("t4 out1", out1, 8'h00);
    check("t4 z", z, 1'b1);
    check("t4 pc", num, 8'h06);

    // logic, move, shifts and a taken carry jump
    pq = '{8'hE0, 8'hA5, 8'hE4, 8'h0F, 8'h41, 8'h19, 8'h7C, 8'h5B,
           8'hA0, 8'hB4, 8'hD2, 8'h0D, 8'h84, 8'h61, 8'hF0};
    load(8'h00);
    start();
    wait_halt("t5");
    check("t5 out1", out1, 8'h0D);
    check("t5 out2", out2, 8'h07);
    check("t5 out3", out3, 8'hFF);
    check("t5 out4", out4, 8'hFF);
    check("t5 c", c, 1'b0);

    // reset pulse during the EXEC of an ADD
    pq = '{8'hE0, 8'h12, 8'hE4, 8'h34, 8'h21, 8'hF0};
    load(8'h00);
    start();
    for (int i = 0; i < 100 && !(state == 3'd3 && opcode == 4'h2); i++) @(negedge clk1);
    check("t6 reached ADD exec", (state == 3'd3 && opcode == 4'h2), 1'b1);
    check("t6 pre R0", out1, 8'h12);
    chk_en = 1'b0;
    rst = 1'b1;
    @(posedge clk1); #1;
    check("t6 abort R0", out1, 8'h00);
    check("t6 abort R1", out2, 8'h00);
    check("t6 abort R2", out3, 8'h00);
    check("t6 abort R3", out4, 8'h00);
    check("t6 abort pc", num, 8'h00);
    check("t6 abort state", state, 3'd1);
    #1;
    go();
    wait_halt("t6");
    check("t6 rerun R0", out1, 8'h46);

    // load write while running: patched byte becomes the LDB operand
    pq = '{8'hD0, 8'h1E};
    load(8'h00);
    pq = '{8'hE0, 8'h55, 8'hF0};
    load(8'h1E);
    start();
    done = 1'b1; in = 16'h1FAA; m_mem[8'h1F] = 8'hAA;
    #1;
    check("t7 w1", w1, 1'b1);
    @(posedge clk1); #1;
    check("t7 d_d high", d_d, 1'b1);
    done = 1'b0;
    @(posedge clk1); #1;
    check("t7 d_d low", d_d, 1'b0);
    wait_halt("t7");
    check("t7 out1", out1, 8'hAA);
    check("t7 pc", num, 8'h21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
